nios_project_13_led_driver: RTL and testbench

- Downstream of the 4-bit LED PIO output register; consumes its `out_port` word and drives the physical LED pins.
- Adds global PWM brightness control and a per-LED blink mask, both configured through a small Avalon-MM slave on the same Nios II fabric.
- LED on/off intent stays with the PIO. This block only shapes the signal: it dims it and gates it with the blink phase.

---
 rtl/nios_project_13_led_driver_if.sv | 13 +
 rtl/nios_project_13_led_driver.sv | 125 ++++++++++++
 tb/tb_nios_project_13_led_driver.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/nios_project_13_led_driver_if.sv
// Avalon-MM slave bus for the LED driver configuration registers.
interface nios_project_13_led_driver_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, output chipselect, output write_n, output writedata,
                  input readdata);
  modport slave  (input address, input chipselect, input write_n, input writedata,
                  output readdata);
endinterface

// File: rtl/nios_project_13_led_driver.sv
// LED pin driver: PWM dimming plus per-LED blink gating of the PIO LED word.
// Optional LED_DRIVER_ACTIVE_LOW_EN inverts the pin drive (reset value all ones).
module nios_project_13_led_driver #(
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned NUM_LEDS = 4
) (
  input  logic                clk,
  input  logic                reset,
  nios_project_13_led_driver_if.slave bus,
  input  logic [NUM_LEDS-1:0] led_in,
  output logic [NUM_LEDS-1:0] led_out
);

`ifdef LED_DRIVER_ACTIVE_LOW_EN
  localparam logic POLARITY = 1'b1;
`else
  localparam logic POLARITY = 1'b0;
`endif

  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

  logic                en;
  logic [NUM_LEDS-1:0] blink_mask;
  logic [7:0]          duty;
  logic [15:0]         blink_div;
  logic [15:0]         pre_cnt;
  logic [7:0]          pwm_cnt;
  logic [15:0]         blink_cnt;
  logic                phase;

  logic                wr;
  logic                tick;
  logic                pwm_on;
  logic [NUM_LEDS-1:0] drive;
  logic                unused_wdata;

  assign wr           = bus.chipselect & ~bus.write_n;
  assign tick         = (pre_cnt == PRE_MAX);
  assign unused_wdata = ^bus.writedata[31:16];

  always_comb begin
    if (duty == 8'hFF)
      pwm_on = 1'b1;
    else if (duty == 8'h00)
      pwm_on = 1'b0;
    else
      pwm_on = (pwm_cnt < duty);
  end

  assign drive = {NUM_LEDS{en & pwm_on}} & led_in & (~blink_mask | {NUM_LEDS{phase}});

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      2'd0: begin
        bus.readdata[0]              = en;
        bus.readdata[4 +: NUM_LEDS]  = blink_mask;
      end
      2'd1: bus.readdata[7:0]  = duty;
      2'd2: bus.readdata[15:0] = blink_div;
      default: begin
        bus.readdata[0]    = phase;
        bus.readdata[15:8] = pwm_cnt;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en         <= 1'b0;
      blink_mask <= '0;
      duty       <= 8'hFF;
    end else if (wr) begin
      case (bus.address)
        2'd0: begin
          en         <= bus.writedata[0];
          blink_mask <= bus.writedata[4 +: NUM_LEDS];
        end
        2'd1:    duty <= bus.writedata[7:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 16'd1;
      pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  // A BLINK_DIV write restarts the blink phase and wins over a coincident tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_div <= 16'd500;
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (wr && bus.address == 2'd2) begin
      blink_div <= bus.writedata[15:0];
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (tick) begin
      if (blink_div == 16'd0) begin
        blink_cnt <= '0;
        phase     <= 1'b1;
      end else if (blink_cnt == blink_div - 16'd1) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      led_out <= {NUM_LEDS{POLARITY}};
    else
      led_out <= {NUM_LEDS{POLARITY}} ^ drive;
  end

endmodule

// File: tb/tb_nios_project_13_led_driver.sv
// Directed self-checking bench for the LED driver (PRESCALE=4 instance).
module tb_nios_project_13_led_driver;

`ifdef LED_DRIVER_ACTIVE_LOW_EN
  localparam logic [3:0] POL = 4'hF;
`else
  localparam logic [3:0] POL = 4'h0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] led_in = 4'h0;
  logic [3:0] led_out;

  int unsigned errors = 0;
  int unsigned checks = 0;

  nios_project_13_led_driver_if bus_if ();

  nios_project_13_led_driver #(.PRESCALE(4), .NUM_LEDS(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus_if.slave),
    .led_in  (led_in),
    .led_out (led_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus_if.address    = a;
    bus_if.writedata  = d;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    step(1);
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
  endtask

  task automatic read_check(input string tag, input logic [1:0] a,
                            input logic [31:0] mask, input logic [31:0] exp);
    bus_if.address = a;
    #1;
    check(tag, bus_if.readdata & mask, exp);
  endtask

  initial begin
    int unsigned on_cnt [4];
    int unsigned bad;
    int unsigned ntr;
    int unsigned last_tr;
    logic        prev;
    logic        found;

    bus_if.address    = 2'd0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = '0;

    // 1: reset values
    step(3);
    check("led_in_reset", {28'd0, led_out}, {28'd0, POL});
    reset = 1'b0;
    read_check("ctrl_rst",   2'd0, 32'hFFFF_FFFF, 32'h0);
    read_check("duty_rst",   2'd1, 32'hFFFF_FFFF, 32'hFF);
    read_check("div_rst",    2'd2, 32'hFFFF_FFFF, 32'h1F4);
    read_check("status_rst", 2'd3, 32'hFFFF_00FF, 32'h1);
    bus_write(2'd3, 32'h0);
    read_check("status_ro",  2'd3, 32'hFFFF_00FF, 32'h1);

    // 2: passthrough with 1 clk latency, EN gating
    bus_write(2'd1, 32'hFF);
    bus_write(2'd0, 32'h1);
    check("pass_pre", {28'd0, led_out}, {28'd0, POL});
    led_in = 4'b1010;
    step(1);
    check("pass_1010", {28'd0, led_out}, {28'd0, 4'b1010 ^ POL});
    step(3);
    check("pass_1010_steady", {28'd0, led_out}, {28'd0, 4'b1010 ^ POL});
    led_in = 4'b0101;
    step(1);
    check("pass_0101", {28'd0, led_out}, {28'd0, 4'b0101 ^ POL});
    bus_write(2'd0, 32'h0);
    step(1);
    check("en_off", {28'd0, led_out}, {28'd0, POL});

    // 3: PWM duty 0x40 -> 64 of 256 cycles; duty 0 -> always off
    bus_write(2'd0, 32'h1);
    led_in = 4'hF;
    bus_write(2'd1, 32'h40);
    step(2);
    for (int i = 0; i < 4; i++) on_cnt[i] = 0;
    for (int n = 0; n < 256; n++) begin
      for (int i = 0; i < 4; i++)
        if ((led_out[i] ^ POL[i]) == 1'b1) on_cnt[i]++;
      step(1);
    end
    for (int i = 0; i < 4; i++)
      check($sformatf("pwm40_led%0d", i), on_cnt[i], 32'd64);
    bus_write(2'd1, 32'h0);
    step(2);
    bad = 0;
    for (int n = 0; n < 300; n++) begin
      if ((led_out ^ POL) != 4'h0) bad++;
      step(1);
    end
    check("duty0_off", bad, 32'd0);

    // 4: blink LED0, half period 3 ticks * 4 clks = 12 clks
    bus_write(2'd1, 32'hFF);
    bus_write(2'd0, 32'h11);
    bus_write(2'd2, 32'd3);
    prev = led_out[0] ^ POL[0];
    ntr = 0;
    last_tr = 0;
    bad = 0;
    for (int unsigned n = 1; n <= 80; n++) begin
      step(1);
      if ((led_out[3:1] ^ POL[3:1]) != 3'b111) bad++;
      if ((led_out[0] ^ POL[0]) != prev) begin
        if (ntr > 0) check($sformatf("blink_interval%0d", ntr), n - last_tr, 32'd12);
        ntr++;
        last_tr = n;
        prev = led_out[0] ^ POL[0];
      end
    end
    check("blink_enough_toggles", {31'd0, ntr >= 3}, 32'd1);
    check("blink_others_high", bad, 32'd0);
    bus_write(2'd2, 32'd0);
    step(1);
    bad = 0;
    for (int n = 0; n < 40; n++) begin
      if ((led_out ^ POL) != 4'hF) bad++;
      step(1);
    end
    check("div0_steady", bad, 32'd0);

    // 5: BLINK_DIV write coincident with a toggling tick
    bus_write(2'd2, 32'd1);
    bus_if.address = 2'd3;
    #1;
    prev = bus_if.readdata[0];
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      step(1);
      if (prev == 1'b0 && bus_if.readdata[0] == 1'b1) found = 1'b1;
      prev = bus_if.readdata[0];
    end
    check("tick_found", {31'd0, found}, 32'd1);
    if (found) begin
      step(3);
      bus_write(2'd2, 32'd2);
      read_check("coincide_phase", 2'd3, 32'h1, 32'h1);
      step(7);
      check("coincide_hold", {31'd0, bus_if.readdata[0]}, 32'd1);
      step(1);
      check("coincide_toggle", {31'd0, bus_if.readdata[0]}, 32'd0);
    end

    // reset mid-blink
    reset = 1'b1;
    step(1);
    check("reset_led", {28'd0, led_out}, {28'd0, POL});
    reset = 1'b0;
    read_check("ctrl_rst2",   2'd0, 32'hFFFF_FFFF, 32'h0);
    read_check("duty_rst2",   2'd1, 32'hFFFF_FFFF, 32'hFF);
    read_check("div_rst2",    2'd2, 32'hFFFF_FFFF, 32'h1F4);
    read_check("status_rst2", 2'd3, 32'hFFFF_00FF, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
